inst_encoder: RTL



---
 rtl/inst_encoder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/inst_encoder.sv
// Packs RV32I instruction fields into 32-bit words for instruction-memory fill,
// behind a one-entry valid/ready output register with sticky error capture.
// Optional field/opcode checking is enabled by defining INST_ENC_CHECK_EN.
module inst_encoder #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_type,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] waddr,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  typedef enum logic [2:0] {
    T_I     = 3'd0,
    T_ISTAR = 3'd1,
    T_S     = 3'd2,
    T_B     = 3'd3,
    T_U     = 3'd4,
    T_J     = 3'd5,
    T_R     = 3'd6,
    T_RSVD  = 3'd7
  } op_type_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  op_type_e    ty;
  logic [31:0] enc_inst;
  logic        check_flag;
  logic        word_flag;
  logic        flag_q;
  logic        accept;
  logic        emit;

  assign ty       = op_type_e'(op_type);
  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    enc_inst = NOP;
    case (ty)
      T_R:     enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
      T_I:     enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
      T_ISTAR: enc_inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      T_S:     enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      T_B:     enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      T_U:     enc_inst = {imm[31:12], rd, opcode};
      T_J:     enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: enc_inst = NOP;
    endcase
  end

`ifdef INST_ENC_CHECK_EN
  logic range_ok;
  logic opc_ok;

  // The word is still packed from truncated fields; the checks only flag it.
  always_comb begin
    range_ok = 1'b1;
    opc_ok   = 1'b1;
    case (ty)
      T_I: begin
        range_ok = (imm[31:11] == {21{imm[11]}});
        opc_ok   = (opcode == 7'b0010011) || (opcode == 7'b1100111) ||
                   (opcode == 7'b1110011);
      end
      T_ISTAR: begin
        range_ok = (imm[31:5] == 27'd0);
        opc_ok   = (opcode == 7'b0010011);
      end
      T_S: begin
        range_ok = (imm[31:11] == {21{imm[11]}});
        opc_ok   = (opcode == 7'b0100011);
      end
      T_B: begin
        range_ok = (imm[31:12] == {20{imm[12]}}) && !imm[0];
        opc_ok   = (opcode == 7'b1100011);
      end
      T_U: begin
        range_ok = (imm[11:0] == 12'd0);
        opc_ok   = (opcode == 7'b0010111) || (opcode == 7'b0110111);
      end
      T_J: begin
        range_ok = (imm[31:20] == {12{imm[20]}}) && !imm[0];
        opc_ok   = (opcode == 7'b1101111);
      end
      T_R: begin
        range_ok = 1'b1;
        opc_ok   = (opcode == 7'b0110011);
      end
      default: begin
        range_ok = 1'b1;
        opc_ok   = 1'b1;
      end
    endcase
    check_flag = !range_ok || !opc_ok;
  end
`else
  assign check_flag = 1'b0;
`endif

  assign word_flag = (ty == T_RSVD) || check_flag;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, matching flop behaviour in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      inst      <= '0;
      flag_q    <= 1'b0;
      waddr     <= BASE_ADDR;
      err       <= 1'b0;
      err_addr  <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
      flag_q    <= 1'b0;
      waddr     <= BASE_ADDR;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (emit) begin
        waddr <= waddr + ADDR_W'(4);
        if (flag_q) begin
          err <= 1'b1;
          if (!err) err_addr <= waddr;
        end
      end
      if (accept) begin
        out_valid <= 1'b1;
        inst      <= enc_inst;
        flag_q    <= word_flag;
      end else if (emit) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
